// File: rtl/zaxxon_ioctl_pkg.sv
// Shared types and constants for the zaxxon ioctl upload/download path.
package zaxxon_ioctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READY,
        ST_FETCH,
        ST_DONE
    } state_e;

    localparam logic [7:0]  IDX_ROM     = 8'd0;
    localparam logic [7:0]  IDX_UPLOAD  = 8'd4;
    localparam logic [7:0]  IDX_DIP     = 8'd254;
    localparam logic [7:0]  PAD_DEFAULT = 8'hFF;

    localparam int unsigned IOCTL_AW    = 25;
    localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/ioctl_upload_server_if.sv
// hps_io ioctl byte channel: request side (master = hps_io) and serving side (slave).
interface ioctl_upload_server_if;
    import zaxxon_ioctl_pkg::*;

    logic                ioctl_upload;
    logic [7:0]          ioctl_index;
    logic                ioctl_rd;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_din;
    logic                ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait
    );

endinterface

// File: rtl/ioctl_upload_server.sv
// Serves save-RAM bytes to the HPS during an ioctl upload, pausing the core while it does.
module ioctl_upload_server
    import zaxxon_ioctl_pkg::*;
#(
    parameter int unsigned AW           = 12,
    parameter int unsigned SIZE         = 4096,
    parameter int unsigned BASE         = 0,
    parameter int unsigned RD_LAT       = 1,
    parameter logic [7:0]  UPLOAD_INDEX = IDX_UPLOAD,
    parameter logic [7:0]  PAD          = PAD_DEFAULT
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    ioctl_upload_server_if.slave hps,
    output logic                 pause_req,
    input  logic                 pause_ack,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_rd,
    input  logic [7:0]           ram_dout,
    output logic                 busy,
    output logic                 err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              pause_q, pause_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic              rrd_q, rrd_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              active_c;
    logic              in_range_c;

    // Upload window addressed to us; upper address bits only matter for the range test.
    assign active_c   = hps.ioctl_upload && (hps.ioctl_index == UPLOAD_INDEX);
    assign in_range_c = 32'(hps.ioctl_addr) < SIZE;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wait_d  = wait_q;
        pause_d = pause_q;
        raddr_d = raddr_q;
        rrd_d   = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (active_c) begin
                    state_d = ST_REQ;
                    pause_d = 1'b1;
                    wait_d  = 1'b1;
                end
            end
            ST_REQ: begin
                wait_d = 1'b1;
                if (!active_c) begin
                    state_d = ST_DONE;
                end else if (pause_ack) begin
                    state_d = ST_READY;
                    wait_d  = 1'b0;
                end
            end
            ST_READY: begin
                if (!active_c) begin
                    state_d = ST_DONE;
                end else if (!pause_ack) begin
                    // Core resumed under us: stall the HPS, RAM port is not ours.
                    wait_d = 1'b1;
                end else begin
                    wait_d = 1'b0;
                    if (hps.ioctl_rd) begin
                        if (in_range_c) begin
                            raddr_d = hps.ioctl_addr[AW-1:0] + AW'(BASE);
                            rrd_d   = 1'b1;
                            wait_d  = 1'b1;
                            cnt_d   = CNT_W'(RD_LAT);
                            state_d = ST_FETCH;
                        end else begin
                            din_d = PAD;
                        end
                    end
                end
            end
            ST_FETCH: begin
                if (active_c && hps.ioctl_rd) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    din_d   = ram_dout;
                    wait_d  = !pause_ack;
                    state_d = active_c ? ST_READY : ST_DONE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    wait_d = 1'b1;
                end
            end
            ST_DONE: begin
                pause_d = 1'b0;
                wait_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            wait_q  <= 1'b0;
            pause_q <= 1'b0;
            raddr_q <= '0;
            rrd_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            pause_q <= pause_d;
            raddr_q <= raddr_d;
            rrd_q   <= rrd_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign hps.ioctl_din  = din_q;
    assign hps.ioctl_wait = wait_q;
    assign pause_req      = pause_q;
    assign ram_addr       = raddr_q;
    assign ram_rd         = rrd_q;
    assign busy           = busy_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Randomized scoreboard bench for ioctl_upload_server with a latency-2 RAM and a wrapping BASE.
module tb_ioctl_upload_server;
    import zaxxon_ioctl_pkg::*;

    localparam int unsigned AW     = 12;
    localparam int unsigned SIZE   = 4096;
    localparam int unsigned BASE   = 32'hFF0;
    localparam int unsigned RD_LAT = 2;

    logic            clk_sys;
    logic            reset;
    logic            pause_req;
    logic            pause_ack;
    logic [AW-1:0]   ram_addr;
    logic            ram_rd;
    logic [7:0]      ram_dout;
    logic            busy;
    logic            err;

    ioctl_upload_server_if bus();

    ioctl_upload_server #(
        .AW(AW), .SIZE(SIZE), .BASE(BASE), .RD_LAT(RD_LAT),
        .UPLOAD_INDEX(IDX_UPLOAD), .PAD(PAD_DEFAULT)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .hps(bus),
        .pause_req(pause_req),
        .pause_ack(pause_ack),
        .ram_addr(ram_addr),
        .ram_rd(ram_rd),
        .ram_dout(ram_dout),
        .busy(busy),
        .err(err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Save-RAM model: data valid exactly RD_LAT cycles after the strobe, junk otherwise.
    logic [7:0] mem [SIZE];
    logic       p1_v, p2_v;
    logic [7:0] p1_d, p2_d, junk;
    always @(posedge clk_sys) begin
        p1_v <= ram_rd;
        p1_d <= mem[ram_addr];
        p2_v <= p1_v;
        p2_d <= p1_d;
        junk <= 8'($urandom);
    end
    assign ram_dout = (p2_v === 1'b1) ? p2_d : junk;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] ram_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_ram_seen = 0;
    int            n_ram_exp = 0;
    logic [7:0]    last_din = 8'h00;

    // Reference: out-of-range returns PAD, otherwise the byte at (addr + BASE) mod 2^AW.
    function automatic logic [AW-1:0] ref_ram_addr(input logic [24:0] a);
        int unsigned ai = 32'(a);
        return AW'((ai + BASE) % (1 << AW));
    endfunction

    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        if (32'(a) >= SIZE) return PAD_DEFAULT;
        return mem[ref_ram_addr(a)];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ioctl_din"}, 32'(bus.ioctl_din), 32'h0);
        check({tag, " ioctl_wait"}, 32'(bus.ioctl_wait), 32'h0);
        check({tag, " pause_req"}, 32'(pause_req), 32'h0);
        check({tag, " ram_rd"}, 32'(ram_rd), 32'h0);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " err"}, 32'(err), 32'h0);
    endtask

    // Data monitor: after an accepted request, the first cycle with wait low carries the byte.
    task automatic mon_data();
        int   age = 0;
        logic pending = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                pending = 1'b0;
            end else if (pending) begin
                age++;
                if (!bus.ioctl_wait) begin
                    pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL data: byte 0x%0h delivered, none expected", bus.ioctl_din);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("din @%0h", e.addr), 32'(bus.ioctl_din), 32'(e.data));
                        if (e.lat != 0)
                            check($sformatf("latency @%0h", e.addr), 32'(age), 32'(e.lat));
                    end
                end else if (age > 64) begin
                    pending = 1'b0;
                    timeout("data return");
                end
            end else if (bus.ioctl_rd && bus.ioctl_upload && bus.ioctl_index == IDX_UPLOAD) begin
                pending = 1'b1;
                age     = 0;
            end
        end
    endtask

    // RAM-side monitor: every read strobe must match an expected in-range address.
    task automatic mon_ram();
        logic [AW-1:0] ea;
        forever begin
            @(negedge clk_sys);
            if (!reset && ram_rd === 1'b1) begin
                n_ram_seen++;
                if (ram_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ram_rd: strobe at 0x%0h with no in-range request", ram_addr);
                end else begin
                    ea = ram_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(ea));
                end
            end
        end
    endtask

    task automatic issue_rd(input logic [24:0] a, input bit chk_lat);
        exp_t e;
        e.addr = a;
        e.data = ref_byte(a);
        e.lat  = !chk_lat ? 0 : (32'(a) >= SIZE) ? 1 : int'(RD_LAT) + 2;
        if (32'(a) < SIZE) begin
            ram_q.push_back(ref_ram_addr(a));
            n_ram_exp++;
        end
        exp_q.push_back(e);
        last_din = e.data;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = a;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.ioctl_wait !== 1'b0) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) timeout(name);
    endtask

    task automatic enter_upload();
        int n = 0;
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = IDX_UPLOAD;
        @(posedge clk_sys); #1;
        pause_ack = 1'b1;
        @(negedge clk_sys);
        while (!(busy === 1'b1 && bus.ioctl_wait === 1'b0) && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 50) timeout("enter upload");
    endtask

    initial begin
        logic [24:0] a;
        logic [7:0]  other_idx [2];

        for (int i = 0; i < int'(SIZE); i++) mem[i] = 8'($urandom);
        mem[12'hFF5] = 8'hA7;
        other_idx[0] = IDX_ROM;
        other_idx[1] = IDX_DIP;

        reset            = 1'b1;
        pause_ack        = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'h00;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;

        fork
            mon_data();
            mon_ram();
        join_none

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_vals("reset");
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // Uploads for other indices are ignored entirely.
        for (int k = 0; k < 2; k++) begin
            bus.ioctl_upload = 1'b1;
            bus.ioctl_index  = other_idx[k];
            pause_ack        = 1'b1;
            for (int j = 0; j < 3; j++) begin
                @(posedge clk_sys); #1;
                bus.ioctl_rd   = 1'b1;
                bus.ioctl_addr = 25'($urandom_range(0, SIZE - 1));
                @(posedge clk_sys); #1;
                bus.ioctl_rd   = 1'b0;
            end
            repeat (3) @(negedge clk_sys);
            check($sformatf("idx %0d busy", other_idx[k]), 32'(busy), 32'h0);
            check($sformatf("idx %0d pause_req", other_idx[k]), 32'(pause_req), 32'h0);
            check($sformatf("idx %0d wait", other_idx[k]), 32'(bus.ioctl_wait), 32'h0);
            check($sformatf("idx %0d din", other_idx[k]), 32'(bus.ioctl_din), 32'(last_din));
        end
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b0;
        pause_ack        = 1'b0;

        // Pause handshake: ack withheld for 10 cycles.
        @(posedge clk_sys); #1;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index  = IDX_UPLOAD;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_sys); #1;
            @(negedge clk_sys);
            check($sformatf("req wait c%0d", i), 32'(bus.ioctl_wait), 32'h1);
            check($sformatf("req pause c%0d", i), 32'(pause_req), 32'h1);
            check($sformatf("req busy c%0d", i), 32'(busy), 32'h1);
        end
        @(posedge clk_sys); #1;
        pause_ack = 1'b1;
        @(negedge clk_sys);
        check("wait ack cycle", 32'(bus.ioctl_wait), 32'h1);
        @(negedge clk_sys);
        check("wait after ack", 32'(bus.ioctl_wait), 32'h0);
        check("busy after ack", 32'(busy), 32'h1);

        // Directed boundary requests.
        issue_rd(25'h005, 1'b1);       drain("addr 5");
        issue_rd(25'h020, 1'b1);       drain("addr 0x20 wrap");
        issue_rd(25'd4096, 1'b1);      drain("addr 4096");
        issue_rd(25'd4095, 1'b1);      drain("addr 4095");
        issue_rd(25'h1FF_FFFF, 1'b1);  drain("addr max");

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = 25'(SIZE + $urandom_range(0, 32'h1FF_FFFF - SIZE));
            else
                a = 25'($urandom_range(0, SIZE - 1));
            repeat ($urandom_range(0, 2)) @(posedge clk_sys);
            issue_rd(a, 1'b1);
            drain("random");
        end
        check("err clean", 32'(err), 32'h0);

        // Pause ack drops mid-fetch: wait held until ack returns, byte preserved.
        issue_rd(25'($urandom_range(0, SIZE - 1)), 1'b0);
        pause_ack = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("wait held ack low", 32'(bus.ioctl_wait), 32'h1);
        @(posedge clk_sys); #1;
        pause_ack = 1'b1;
        drain("ack drop");

        // Extra request during a fetch sets the sticky error.
        issue_rd(25'h123, 1'b1);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h456;
        @(posedge clk_sys); #1;
        bus.ioctl_rd   = 1'b0;
        drain("overlap");
        check("err set", 32'(err), 32'h1);
        issue_rd(25'($urandom_range(0, SIZE - 1)), 1'b1);
        drain("after err");
        check("err sticky", 32'(err), 32'h1);

        // Upload window closes mid-fetch: byte still delivered, then release.
        issue_rd(25'h7FF, 1'b1);
        bus.ioctl_upload = 1'b0;
        drain("upload drop");
        repeat (2) @(negedge clk_sys);
        check("drop pause_req", 32'(pause_req), 32'h0);
        check("drop busy", 32'(busy), 32'h0);
        check("drop wait", 32'(bus.ioctl_wait), 32'h0);
        check("drop din held", 32'(bus.ioctl_din), 32'(last_din));
        check("drop err sticky", 32'(err), 32'h1);
        @(posedge clk_sys); #1;
        pause_ack = 1'b0;

        // Reset on the second fetch cycle aborts everything.
        enter_upload();
        issue_rd(25'h0AB, 1'b1);
        @(posedge clk_sys); #1;
        reset            = 1'b1;
        bus.ioctl_upload = 1'b0;
        pause_ack        = 1'b0;
        exp_q.delete();
        last_din         = 8'h00;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check_reset_vals("mid-fetch reset");
        repeat (3) @(negedge clk_sys);
        check("idle after reset", 32'(busy), 32'h0);

        check("ram_rd count", 32'(n_ram_seen), 32'(n_ram_exp));
        check("ram queue empty", 32'(ram_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
